ray_caster_tiled: RTL
=====================

// Module: ray_caster_tiled
// PURPOSE
//  Next-generation primary-ray front end. Walks the frame in TILE_W x TILE_H tiles and emits SPP
//  samples per pixel. Drives an internal ray_maker (latency MAKER_LAT) and buffers its rays in a
//  credit-guarded FIFO. Rays leave on a valid/ready handshake, so the downstream tracer can stall.
//  Sits between the camera registers and the ray tracer / sample accumulator.
// PARAMETERS
//  WIDTH       1280  frame width in pixels; must be a multiple of TILE_W
//  HEIGHT      720   frame height in pixels; must be a multiple of TILE_H
//  TILE_W      16    tile width in pixels, power of 2
//  TILE_H      16    tile height in pixels, power of 2
//  SPP         1     samples per pixel (1..16); consecutive rays for one pixel
//  MAKER_LAT   8     fixed ray_maker latency in cycles, new_ray -> ray_valid
//  FIFO_DEPTH  16    output FIFO entries; must be >= MAKER_LAT+2
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous, active-low reset
//  cam           in   camera     camera; sampled only on an accepted start
//  start         in   1          pulse; begins a frame when state is IDLE or DONE
//  busy          out  1          high from an accepted start until frame_done
//  frame_done    out  1          1-cycle pulse after the last ray handshake of a frame
//  ray_origin    out  fp24_vec3  FIFO head: ray origin
//  ray_dir       out  fp24_vec3  FIFO head: ray direction
//  pixel_h       out  11         FIFO head: pixel column
//  pixel_v       out  10         FIFO head: pixel row
//  sample_idx    out  4          FIFO head: sample number 0..SPP-1
//  last_sample   out  1          FIFO head: sample_idx == SPP-1
//  ray_valid     out  1          FIFO non-empty
//  ray_ready     in   1          downstream accepts the head when ray_valid && ray_ready
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - state=IDLE; all counters, credits and FIFO pointers = 0.
//   - busy=0, frame_done=0, ray_valid=0; payload outputs = 0.
//   - ray_maker pipeline valids are flushed. A frame in flight is aborted; no partial output.
//  FSM:
//   - IDLE -start-> RUN. Latch cam. Clear tile, pixel and sample counters.
//   - RUN: after the final issue (last tile, last pixel, sample SPP-1) -> DRAIN.
//   - DRAIN: when outstanding==0 and the FIFO empties by a handshake -> DONE. frame_done pulses
//     the cycle after that last handshake.
//   - DONE -start-> RUN, same as IDLE. start in RUN/DRAIN is ignored.
//  Scan order:
//   - Tiles go row-major across the frame. Pixels are row-major inside a tile.
//   - sample_idx is the fastest counter, so SPP consecutive rays share a pixel.
//   - Coordinates: pixel_h = tile_x*TILE_W + px; pixel_v = tile_y*TILE_H + py.
//   - Counter wrap: sample SPP-1 -> 0 advances px; px TILE_W-1 -> 0 advances py; py TILE_H-1 -> 0
//     advances tile_x; tile_x wraps -> tile_y++.
//  Issue/credit rule:
//   - issue = (state==RUN) && (outstanding + fifo_count < FIFO_DEPTH).
//   - An issue pulses new_ray into ray_maker with the current pixel. sample_idx and last_sample
//     travel in a MAKER_LAT-deep sideband shift register aligned with ray_maker.
//   - outstanding counts +1 per issue, -1 per ray_maker ray_valid; same cycle leaves it unchanged.
//   - The FIFO can never overflow; a ray_maker output is always written the cycle it appears.
//  FIFO:
//   - First-word-fall-through; head payload held stable while ray_valid && !ray_ready.
//   - Simultaneous write and read when full or empty is legal. Empty+write: ray_valid the next
//     cycle, no same-cycle bypass.
//  Throughput and latency:
//   - 1 ray/cycle sustained with ray_ready held high.
//   - First ray_valid at start + 1 + MAKER_LAT + 1 cycles.
//   - Total rays per frame = WIDTH*HEIGHT*SPP; exactly that many handshakes per frame.
//  Widths: internal counters use $clog2 of their range, zero-extended onto pixel_h and pixel_v.
// TESTING  (WIDTH=8 HEIGHT=4 TILE_W=4 TILE_H=2 SPP=2 MAKER_LAT=4 FIFO_DEPTH=8)
//  1 Order, ready=1. Rays: (0,0)s0, (0,0)s1, (1,0)s0 ... (3,1)s1, then (4,0)s0.
//    Last ray (7,3)s1 with last_sample=1. 64 handshakes, then one frame_done.
//  2 Latency. start at cycle 0 -> first ray_valid at cycle 6, carrying pixel (0,0), sample 0.
//  3 Backpressure. Hold ray_ready=0 for 40 cycles. Issues stop with 8 held (FIFO+outstanding);
//    head stays (0,0)s0; nothing lost or duplicated after release.
//  4 Random ray_ready, 50% duty. Output sequence equals scenario 1; busy low only after the 64th
//    handshake.
//  5 Reset mid-frame. rst=0 for 1 cycle after 20 rays -> ray_valid=0, busy=0 next cycle. The next
//    start yields a full 64-ray frame from (0,0)s0.
//  6 start during RUN is ignored. start in DONE re-runs the frame; cam changed between frames is
//    used only in frame 2.

Source files
------------

// File: rtl/ray_caster_tiled.sv
// Tiled primary-ray front end: scans the frame tile by tile and feeds a fixed-latency
// ray maker whose results are buffered in a credit-guarded FWFT FIFO.
module ray_caster_tiled #(
   parameter int WIDTH      = 1280,
   parameter int HEIGHT     = 720,
   parameter int TILE_W     = 16,
   parameter int TILE_H     = 16,
   parameter int SPP        = 1,
   parameter int MAKER_LAT  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   // camera = {origin, corner_dir, step_h, step_v}; each vec3 = {x, y, z}, 24-bit fixed-point components
   input  logic [287:0]  cam,
   input  logic          start,
   output logic          busy,
   output logic          frame_done,
   output logic [71:0]   ray_origin,
   output logic [71:0]   ray_dir,
   output logic [10:0]   pixel_h,
   output logic [9:0]    pixel_v,
   output logic [3:0]    sample_idx,
   output logic          last_sample,
   output logic          ray_valid,
   input  logic          ray_ready
);
   localparam int TX  = WIDTH / TILE_W;
   localparam int TY  = HEIGHT / TILE_H;
   localparam int SW  = (SPP > 1) ? $clog2(SPP) : 1;
   localparam int XW  = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int YW  = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int TXW = (TX > 1) ? $clog2(TX) : 1;
   localparam int TYW = (TY > 1) ? $clog2(TY) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DW  = 72 + 72 + 11 + 10;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [287:0]     cam_reg;
   logic [SW-1:0]    sample_reg;
   logic [XW-1:0]    px_reg;
   logic [YW-1:0]    py_reg;
   logic [TXW-1:0]   tx_reg;
   logic [TYW-1:0]   ty_reg;
   logic [CW-1:0]    outstanding_reg;
   logic [CW-1:0]    count_reg;
   logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic             done_reg;
   logic [DW+4:0]    mem [FIFO_DEPTH];

   logic             issue, start_ok, done_evt, hs;
   logic             last_s, last_px, last_py, last_tx, last_ty;
   logic [CW:0]      credit_sum;
   logic [10:0]      cur_h;
   logic [9:0]       cur_v;
   logic [71:0]      dir_calc;
   logic [DW-1:0]    issue_data;
   logic [4:0]       issue_side;
   logic             pipe_valid [MAKER_LAT];
   logic [DW-1:0]    pipe_data  [MAKER_LAT];
   logic [4:0]       pipe_side  [MAKER_LAT];
   logic             mk_valid;
   logic [DW+4:0]    head;

   assign last_s     = (sample_reg == SW'(SPP - 1));
   assign last_px    = (px_reg == XW'(TILE_W - 1));
   assign last_py    = (py_reg == YW'(TILE_H - 1));
   assign last_tx    = (tx_reg == TXW'(TX - 1));
   assign last_ty    = (ty_reg == TYW'(TY - 1));
   assign credit_sum = {1'b0, outstanding_reg} + {1'b0, count_reg};
   assign ray_valid  = (count_reg != '0);
   assign hs         = ray_valid && ray_ready;
   assign start_ok   = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign busy       = (state_reg == RUN) || (state_reg == DRAIN);
   assign frame_done = done_reg;

   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      done_evt   = 1'b0;
      case (state_reg)
         IDLE, DONE: if (start) state_next = RUN;
         RUN: begin
            issue = (credit_sum < (CW+1)'(FIFO_DEPTH));
            if (issue && last_s && last_px && last_py && last_tx && last_ty) state_next = DRAIN;
         end
         DRAIN: begin
            // Nothing left in the maker, and the final FIFO entry leaves this cycle.
            if (outstanding_reg == '0 && count_reg == CW'(1) && hs) begin
               state_next = DONE;
               done_evt   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_evt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cam_reg    <= '0;
         sample_reg <= '0;
         px_reg     <= '0;
         py_reg     <= '0;
         tx_reg     <= '0;
         ty_reg     <= '0;
      end else if (start_ok) begin
         cam_reg    <= cam;
         sample_reg <= '0;
         px_reg     <= '0;
         py_reg     <= '0;
         tx_reg     <= '0;
         ty_reg     <= '0;
      end else if (issue) begin
         if (!last_s) sample_reg <= sample_reg + 1'b1;
         else begin
            sample_reg <= '0;
            if (!last_px) px_reg <= px_reg + 1'b1;
            else begin
               px_reg <= '0;
               if (!last_py) py_reg <= py_reg + 1'b1;
               else begin
                  py_reg <= '0;
                  if (!last_tx) tx_reg <= tx_reg + 1'b1;
                  else begin
                     tx_reg <= '0;
                     ty_reg <= last_ty ? '0 : ty_reg + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign cur_h = 11'(tx_reg) * 11'(TILE_W) + 11'(px_reg);
   assign cur_v = 10'(ty_reg) * 10'(TILE_H) + 10'(py_reg);

   // dir = corner + h*step_h + v*step_v, per component, modulo 2^24
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dir
         assign dir_calc[gi*24 +: 24] = cam_reg[144 + gi*24 +: 24]
                                      + 24'(cur_h) * cam_reg[72 + gi*24 +: 24]
                                      + 24'(cur_v) * cam_reg[gi*24 +: 24];
      end
   endgenerate

   assign issue_data = {cam_reg[287:216], dir_calc, cur_h, cur_v};
   assign issue_side = {4'(sample_reg), last_s};

   generate
      for (gi = 0; gi < MAKER_LAT; gi++) begin : g_maker
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (!rst) pipe_valid[gi] <= 1'b0;
               else      pipe_valid[gi] <= issue;
               pipe_data[gi] <= issue_data;
               pipe_side[gi] <= issue_side;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (!rst) pipe_valid[gi] <= 1'b0;
               else      pipe_valid[gi] <= pipe_valid[gi-1];
               pipe_data[gi] <= pipe_data[gi-1];
               pipe_side[gi] <= pipe_side[gi-1];
            end
         end
      end
   endgenerate

   assign mk_valid = pipe_valid[MAKER_LAT-1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         outstanding_reg <= '0;
         count_reg       <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
      end else begin
         case ({issue, mk_valid})
            2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
            2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
            default: outstanding_reg <= outstanding_reg;
         endcase
         case ({mk_valid, hs})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (mk_valid) wr_ptr_reg <= (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
         if (hs)       rd_ptr_reg <= (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
   end

   // Credits guarantee a free slot, so maker output is written unconditionally.
   always_ff @(posedge clk) begin
      if (mk_valid) mem[wr_ptr_reg] <= {pipe_data[MAKER_LAT-1], pipe_side[MAKER_LAT-1]};
   end

   assign head = ray_valid ? mem[rd_ptr_reg] : '0;
   assign {ray_origin, ray_dir, pixel_h, pixel_v, sample_idx, last_sample} = head;

endmodule
